// File: rtl/voice_sched_pkg.sv
// Shared types and constants for the wavetable voice scheduler.
// Sweep FSM states, host register map and mix-bus width.
package voice_sched_pkg;

    localparam int SAMPLE_W = 24;
    localparam int MIX_W    = SAMPLE_W + 3;

    localparam logic [3:0] TABLE_BASE  = 4'd0;
    localparam logic [3:0] INC_BASE    = 4'd8;
    localparam logic [3:0] STATUS_ADDR = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/lrclk_edge_sync.sv
// Brings the raw I2S word clock into CLK and flags either edge.
// Detection is held off until the chain is loaded so reset never fakes an edge.
module lrclk_edge_sync (
    input  logic CLK,
    input  logic RESET_N,
    input  logic lrclk,
    output logic frame_start
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [2:0] arm_q, arm_d;

    always_comb begin
        sync_d = {sync_q[0], lrclk};
        prev_d = sync_q[1];
        arm_d  = {arm_q[1:0], 1'b1};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    assign frame_start = arm_q[2] & (sync_q[1] ^ prev_q);

endmodule

// File: rtl/voice_scheduler.sv
// Per-frame voice sweep, phase accumulation and mix, sharing one RAM port with the host.
// Define MIX_SATURATE_EN to clamp the mix to the signed sample range.
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES = 7,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = SAMPLE_W,
    parameter int PHASE_W    = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    LRCLK,
    input  logic [NUM_VOICES-1:0]   voice_en,
    input  logic [3:0]              host_address,
    input  logic                    host_read,
    input  logic                    host_write,
    input  logic [31:0]             host_writedata,
    output logic [31:0]             host_readdata,
    output logic                    host_waitrequest,
    output logic [ADDR_W-1:0]       ram_address,
    output logic                    ram_read,
    output logic                    ram_write,
    output logic [DATA_W-1:0]       ram_writedata,
    input  logic [DATA_W-1:0]       ram_readdata,
    output logic [MIX_W-1:0]        mix_data,
    output logic                    mix_valid,
    output logic                    overrun
);

    localparam int CNT_W = $clog2(NUM_VOICES);

    logic frame_start;

    lrclk_edge_sync u_sync (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .lrclk       (LRCLK),
        .frame_start (frame_start)
    );

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]         phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]         inc_q [NUM_VOICES];
    logic [PHASE_W-1:0]         inc_d [NUM_VOICES];
    logic signed [MIX_W-1:0]    acc_q, acc_d;
    logic                       en_p_q, en_p_d;
    logic                       vld_p_q, vld_p_d;
    logic                       rd_fl_q, rd_fl_d;
    logic                       pend_q, pend_d;
    logic [MIX_W-1:0]           mix_data_q, mix_data_d;
    logic                       mix_valid_q, mix_valid_d;
    logic                       overrun_q, overrun_d;

    logic                       sweep;
    logic                       busy;
    logic                       tbl_sel;
    logic                       inc_sel;
    logic                       host_ok;
    logic                       wr_ack;
    logic                       rd_issue;
    logic signed [MIX_W-1:0]    contrib;

    function automatic logic [MIX_W-1:0] clamp(input logic signed [MIX_W-1:0] v);
`ifdef MIX_SATURATE_EN
        logic signed [MIX_W-1:0] hi;
        logic signed [MIX_W-1:0] lo;
        hi = '0;
        hi[DATA_W-2:0] = '1;
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return v;
`endif
    endfunction

    assign sweep    = (state_q == ISSUE);
    assign busy     = (state_q != IDLE);
    assign tbl_sel  = ~host_address[3];
    assign inc_sel  = host_address[3] && (host_address != STATUS_ADDR);
    assign host_ok  = !busy && !frame_start && !pend_q;
    assign wr_ack   = host_write && host_ok;
    assign rd_issue = host_read && tbl_sel && host_ok && !rd_fl_q;
    assign contrib  = (vld_p_q && en_p_q)
                    ? {{(MIX_W-DATA_W){ram_readdata[DATA_W-1]}}, ram_readdata}
                    : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        inc_d       = inc_q;
        acc_d       = acc_q + contrib;
        en_p_d      = 1'b0;
        vld_p_d     = 1'b0;
        rd_fl_d     = 1'b0;
        pend_d      = 1'b0;
        mix_data_d  = mix_data_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (frame_start && rd_fl_q) begin
                    pend_d = 1'b1;
                end else if (frame_start || pend_q) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
                if (rd_issue) rd_fl_d = 1'b1;
                if (wr_ack && inc_sel) begin
                    inc_d[host_address[2:0]] = host_writedata[PHASE_W-1:0];
                end
                if (wr_ack && host_address == STATUS_ADDR && host_writedata[0]) begin
                    overrun_d = 1'b0;
                end
            end
            ISSUE: begin
                en_p_d  = voice_en[cnt_q];
                vld_p_d = 1'b1;
                // a gated voice restarts its waveform from the table start
                phase_d[cnt_q] = voice_en[cnt_q] ? phase_q[cnt_q] + inc_q[cnt_q] : '0;
                if (cnt_q == CNT_W'(NUM_VOICES - 1)) state_d = DRAIN;
                else cnt_d = cnt_q + 1'b1;
            end
            DRAIN: begin
                mix_data_d  = clamp(acc_d);
                mix_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (frame_start && busy) overrun_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
            acc_q       <= '0;
            en_p_q      <= 1'b0;
            vld_p_q     <= 1'b0;
            rd_fl_q     <= 1'b0;
            pend_q      <= 1'b0;
            mix_data_q  <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            inc_q       <= inc_d;
            acc_q       <= acc_d;
            en_p_q      <= en_p_d;
            vld_p_q     <= vld_p_d;
            rd_fl_q     <= rd_fl_d;
            pend_q      <= pend_d;
            mix_data_q  <= mix_data_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        ram_read         = 1'b0;
        ram_write        = 1'b0;
        ram_address      = '0;
        ram_writedata    = '0;
        host_waitrequest = 1'b0;
        host_readdata    = '0;
        if (RESET_N) begin
            ram_read  = sweep || rd_issue;
            ram_write = wr_ack && tbl_sel;
            ram_address = sweep ? phase_q[cnt_q][PHASE_W-1 -: ADDR_W]
                                : host_address[ADDR_W-1:0];
            if (ram_write) ram_writedata = host_writedata[31 -: DATA_W];
            host_waitrequest = busy
                || (host_write && (frame_start || pend_q))
                || (host_read && tbl_sel && !rd_fl_q);
            if (rd_fl_q) begin
                host_readdata = {ram_readdata, {(32-DATA_W){1'b0}}};
            end else if (host_read && inc_sel) begin
                host_readdata = 32'(inc_q[host_address[2:0]]);
            end else if (host_read && host_address == STATUS_ADDR) begin
                host_readdata = {30'd0, busy, overrun_q};
            end
        end
    end

    assign mix_data  = mix_data_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized scoreboard bench for voice_scheduler against a per-frame reference model.
module tb_voice_scheduler;

    localparam int NV = 7;
    localparam int MW = 27;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          LRCLK = 1'b0;
    logic [NV-1:0] voice_en = '0;
    logic [3:0]    host_address = '0;
    logic          host_read = 1'b0;
    logic          host_write = 1'b0;
    logic [31:0]   host_writedata = '0;
    logic [31:0]   host_readdata;
    logic          host_waitrequest;
    logic [2:0]    ram_address;
    logic          ram_read;
    logic          ram_write;
    logic [23:0]   ram_writedata;
    logic [23:0]   ram_readdata = '0;
    logic [MW-1:0] mix_data;
    logic          mix_valid;
    logic          overrun;

    voice_scheduler dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .LRCLK            (LRCLK),
        .voice_en         (voice_en),
        .host_address     (host_address),
        .host_read        (host_read),
        .host_write       (host_write),
        .host_writedata   (host_writedata),
        .host_readdata    (host_readdata),
        .host_waitrequest (host_waitrequest),
        .ram_address      (ram_address),
        .ram_read         (ram_read),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_readdata     (ram_readdata),
        .mix_data         (mix_data),
        .mix_valid        (mix_valid),
        .overrun          (overrun)
    );

    always #5 CLK = ~CLK;

    logic [23:0] mem [8] = '{default: 24'd0};

    always @(posedge CLK) begin
        if (ram_write) mem[ram_address] <= ram_writedata;
        if (ram_read) ram_readdata <= mem[ram_address];
    end

    // reference model state
    logic [23:0] tbl [8];
    logic [15:0] ph [NV];
    logic [15:0] incm [NV];

    logic [2:0]    exp_addr [$];
    logic [MW-1:0] exp_mix [$];

    int n_cmp = 0;
    int n_err = 0;
    int rd_in_frame = 0;
    int first_cyc = 0;
    int mix_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic predict();
        int s;
        logic [2:0] a;
        s = 0;
        for (int i = 0; i < NV; i++) begin
            a = ph[i][15:13];
            exp_addr.push_back(a);
            if (voice_en[i]) s += int'($signed(tbl[a]));
            ph[i] = voice_en[i] ? ph[i] + incm[i] : 16'h0;
        end
`ifdef MIX_SATURATE_EN
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
`endif
        exp_mix.push_back(s[MW-1:0]);
    endtask

    task automatic toggle_lrclk();
        @(negedge CLK);
        #2 LRCLK = ~LRCLK;
    endtask

    task automatic wait_mix(input int c0);
        int t;
        t = 0;
        while (mix_cnt == c0 && t < 60) begin
            @(negedge CLK);
            t++;
        end
        chk("mix_seen", 64'(mix_cnt - c0), 64'd1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic frame();
        int c0;
        c0 = mix_cnt;
        predict();
        toggle_lrclk();
        wait_mix(c0);
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [31:0] d, output int w);
        @(negedge CLK);
        host_address = a;
        host_writedata = d;
        host_write = 1'b1;
        w = 0;
        #1;
        while (host_waitrequest && w < 60) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("wr_wait_bound", 64'(w < 60), 64'd1);
        @(posedge CLK);
        #1 host_write = 1'b0;
        if (a < 4'd8) tbl[a[2:0]] = d[31:8];
        else if (a != 4'd15) incm[a[2:0]] = d[15:0];
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        int w;
        host_wr(a, d, w);
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [31:0] d);
        int w;
        w = 0;
        @(negedge CLK);
        host_address = a;
        host_read = 1'b1;
        #1;
        while (host_waitrequest && w < 60) begin
            @(negedge CLK);
            #1;
            w++;
        end
        chk("rd_wait_bound", 64'(w < 60), 64'd1);
        d = host_readdata;
        @(posedge CLK);
        #1 host_read = 1'b0;
    endtask

    // monitor: sweep reads and mix results against the scoreboard
    initial begin
        int now_c;
        forever begin
            @(negedge CLK);
            now_c = int'($time / 10);
            if (RESET_N) begin
                if (ram_read && !host_read) begin
                    if (rd_in_frame == 0) first_cyc = now_c;
                    rd_in_frame++;
                    if (exp_addr.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_read: got addr %0d, required no read", ram_address);
                    end else begin
                        chk("rd_addr", 64'(ram_address), 64'(exp_addr.pop_front()));
                    end
                end
                if (mix_valid) begin
                    mix_cnt++;
                    chk("reads_per_frame", 64'(rd_in_frame), 64'd7);
                    chk("mix_latency", 64'(now_c - first_cyc), 64'd8);
                    rd_in_frame = 0;
                    if (exp_mix.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_mix: got %0h, required no mix_valid", mix_data);
                    end else begin
                        chk("mix_data", 64'(mix_data), 64'(exp_mix.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int w, n, t, c0;

        for (int i = 0; i < 8; i++) tbl[i] = '0;
        for (int i = 0; i < NV; i++) begin
            ph[i] = '0;
            incm[i] = '0;
        end

        repeat (3) @(negedge CLK);
        chk("rst_mix_data", 64'(mix_data), 64'd0);
        chk("rst_mix_valid", 64'(mix_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_waitreq", 64'(host_waitrequest), 64'd0);
        chk("rst_ram_read", 64'(ram_read), 64'd0);
        chk("rst_ram_write", 64'(ram_write), 64'd0);
        chk("rst_readdata", 64'(host_readdata), 64'd0);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);

        // ramp table, all voices on, zero increments
        voice_en = 7'h7F;
        for (int i = 0; i < 8; i++) wr(4'(i), 32'(i) << 16);
        for (int i = 0; i < NV; i++) wr(4'(8 + i), 32'd0);
        frame();
        chk("ramp_mix_zero", 64'(mix_data), 64'd0);

        // full-scale sample summed by every voice
        wr(4'd0, 32'h7FFF_FF00);
        frame();
`ifdef MIX_SATURATE_EN
        chk("full_scale_mix", 64'(mix_data), 64'h07F_FFFF);
`else
        chk("full_scale_mix", 64'(mix_data), 64'h37F_FFF9);
`endif

        // single voice stepping through the table and wrapping
        voice_en = 7'h01;
        wr(4'd8, 32'h0000_2000);
        host_rd(4'd8, d);
        chk("inc0_read", 64'(d), 64'h2000);
        repeat (9) frame();
        voice_en = 7'h00;
        repeat (2) frame();
        voice_en = 7'h01;
        frame();

        // randomized tables, increments and gates
        repeat (15) begin
            voice_en = NV'($urandom);
            wr(4'(8 + $urandom_range(0, NV - 1)), $urandom);
            wr(4'($urandom_range(0, 7)), $urandom);
            frame();
        end

        // host write held off by a sweep
        voice_en = 7'h7F;
        c0 = mix_cnt;
        predict();
        toggle_lrclk();
        t = 0;
        while (!ram_read && t < 20) begin
            @(negedge CLK);
            t++;
        end
        host_wr(4'd3, 32'hABCD_EF00, w);
        chk("wr_stalled", 64'(w >= 5), 64'd1);
        wait_mix(c0);
        chk("ram3_content", 64'(mem[3]), 64'hAB_CDEF);
        host_rd(4'd3, d);
        chk("tbl3_read", 64'(d), 64'hABCD_EF00);

        // second edge inside the sweep is dropped
        c0 = mix_cnt;
        predict();
        toggle_lrclk();
        repeat (2) @(negedge CLK);
        toggle_lrclk();
        wait_mix(c0);
        repeat (20) @(negedge CLK);
        chk("single_mix", 64'(mix_cnt - c0), 64'd1);
        chk("overrun_set", 64'(overrun), 64'd1);
        host_rd(4'd15, d);
        chk("status_read", 64'(d), 64'd1);
        wr(4'd15, 32'd1);
        @(negedge CLK);
        chk("overrun_clr", 64'(overrun), 64'd0);

        // reset while voice 3 is being issued
        c0 = mix_cnt;
        predict();
        toggle_lrclk();
        n = 0;
        t = 0;
        while (n < 4 && t < 40) begin
            @(negedge CLK);
            t++;
            if (ram_read && !host_read) n++;
        end
        chk("reached_voice3", 64'(n), 64'd4);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_ram_read", 64'(ram_read), 64'd0);
        chk("arst_mix_data", 64'(mix_data), 64'd0);
        chk("arst_waitreq", 64'(host_waitrequest), 64'd0);
        chk("arst_mix_valid", 64'(mix_valid), 64'd0);
        exp_addr.delete();
        exp_mix.delete();
        rd_in_frame = 0;
        for (int i = 0; i < NV; i++) begin
            ph[i] = '0;
            incm[i] = '0;
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (20) @(negedge CLK);
        chk("no_mix_after_reset", 64'(mix_cnt), 64'(c0));
        frame();
        frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
